// File: rtl/freq_meas_ctrl.sv
// Reciprocal frequency meter sequencer: opens and closes the gate on synchronised fx
// rising edges, latches fx-period and sysclk counts, and serves them as bytes to the MCU.
module freq_meas_ctrl #(
    parameter int CNT_W          = 32,
    parameter int GATE_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic             i_sysclk,
    input  logic             i_reset,
    input  logic             i_fx,
    input  logic             i_start,
    input  logic             i_cont_mode,
    input  logic             i_abort,
    input  logic             i_ack,
    input  logic [2:0]       i_rd_sel,
    output logic [7:0]       o_data_out,
    output logic             o_busy,
    output logic             o_valid,
    output logic             o_irq,
    output logic             o_timeout,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_fx_cnt,
    output logic [CNT_W-1:0] o_base_cnt
);

    localparam int GW = (GATE_CYCLES    > 1) ? $clog2(GATE_CYCLES + 1)    : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_COUNT = 3'd2;
    localparam logic [2:0] S_CLOSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic             r_fx_s1;
    logic             r_fx_s2;
    logic             r_fx_d;
    logic [CNT_W-1:0] r_fx_tmp;
    logic [CNT_W-1:0] r_base_tmp;
    logic [GW-1:0]    r_gate_cnt;
    logic [TW-1:0]    r_to_cnt;
    logic             r_sat;
    logic [CNT_W-1:0] r_fx_cnt;
    logic [CNT_W-1:0] r_base_cnt;
    logic             r_valid;
    logic             r_timeout;
    logic             r_ovf;
    logic [7:0]       r_data;

    logic             w_fx_rise;
    logic             w_to_hit;
    logic             w_fx_max;
    logic             w_base_max;
    logic [CNT_W-1:0] w_fx_fin;
    logic [CNT_W-1:0] w_base_fin;
    logic [31:0]      w_fx32;
    logic [31:0]      w_base32;

    assign w_fx_rise  = r_fx_s2 & ~r_fx_d;
    assign w_to_hit   = (r_to_cnt == TO_LAST);
    assign w_fx_max   = (r_fx_tmp == CNT_MAX);
    assign w_base_max = (r_base_tmp == CNT_MAX);

    // The closing edge's own period and cycle are folded in at the latch, saturating.
    assign w_fx_fin   = w_fx_max   ? CNT_MAX : r_fx_tmp + 1'b1;
    assign w_base_fin = w_base_max ? CNT_MAX : r_base_tmp + 1'b1;

    always_ff @(posedge i_sysclk) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_fx_s1    <= 1'b0;
            r_fx_s2    <= 1'b0;
            r_fx_d     <= 1'b0;
            r_fx_tmp   <= '0;
            r_base_tmp <= '0;
            r_gate_cnt <= '0;
            r_to_cnt   <= '0;
            r_sat      <= 1'b0;
            r_fx_cnt   <= '0;
            r_base_cnt <= '0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_fx_s1 <= i_fx;
            r_fx_s2 <= r_fx_s1;
            r_fx_d  <= r_fx_s2;

            if (i_abort) begin
                r_state  <= S_IDLE;
                r_valid  <= 1'b0;
                r_to_cnt <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state  <= S_ARM;
                            r_to_cnt <= '0;
                        end
                    end

                    S_ARM: begin
                        if (w_fx_rise) begin
                            r_fx_tmp   <= '0;
                            r_base_tmp <= '0;
                            r_gate_cnt <= '0;
                            r_sat      <= 1'b0;
                            r_state    <= S_COUNT;
                        end else if (w_to_hit) begin
                            r_fx_cnt   <= '0;
                            r_base_cnt <= '0;
                            r_timeout  <= 1'b1;
                            r_ovf      <= 1'b0;
                            r_valid    <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end

                    S_COUNT: begin
                        r_gate_cnt <= r_gate_cnt + 1'b1;
                        if (w_base_max) r_sat <= 1'b1;
                        else            r_base_tmp <= r_base_tmp + 1'b1;
                        if (w_fx_rise) begin
                            if (w_fx_max) r_sat <= 1'b1;
                            else          r_fx_tmp <= r_fx_tmp + 1'b1;
                        end
                        // An fx edge in this final cycle is just counted; only CLOSE ends the gate.
                        if (r_gate_cnt == GATE_LAST) begin
                            r_state  <= S_CLOSE;
                            r_to_cnt <= '0;
                        end
                    end

                    S_CLOSE: begin
                        if (w_fx_rise) begin
                            r_fx_cnt   <= w_fx_fin;
                            r_base_cnt <= w_base_fin;
                            r_ovf      <= r_sat | w_fx_max | w_base_max;
                            r_timeout  <= 1'b0;
                            r_valid    <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (w_to_hit) begin
                            r_fx_cnt   <= '0;
                            r_base_cnt <= '0;
                            r_timeout  <= 1'b1;
                            r_ovf      <= 1'b0;
                            r_valid    <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (w_base_max) r_sat <= 1'b1;
                            else            r_base_tmp <= r_base_tmp + 1'b1;
                        end
                    end

                    S_DONE: begin
                        if (i_ack) begin
                            r_valid  <= 1'b0;
                            r_to_cnt <= '0;
                            r_state  <= i_cont_mode ? S_ARM : S_IDLE;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_fx32   = 32'(r_fx_cnt);
    assign w_base32 = 32'(r_base_cnt);

    always_ff @(posedge i_sysclk) begin
        if (!i_reset) begin
            r_data <= 8'h00;
        end else begin
            case (i_rd_sel)
                3'd0:    r_data <= w_fx32[7:0];
                3'd1:    r_data <= w_fx32[15:8];
                3'd2:    r_data <= w_fx32[23:16];
                3'd3:    r_data <= w_fx32[31:24];
                3'd4:    r_data <= w_base32[7:0];
                3'd5:    r_data <= w_base32[15:8];
                3'd6:    r_data <= w_base32[23:16];
                default: r_data <= w_base32[31:24];
            endcase
        end
    end

    assign o_data_out = r_data;
    assign o_busy     = (r_state == S_ARM) || (r_state == S_COUNT) || (r_state == S_CLOSE);
    assign o_valid    = r_valid;
    assign o_irq      = r_valid;
    assign o_timeout  = r_timeout;
    assign o_ovf      = r_ovf;
    assign o_fx_cnt   = r_fx_cnt;
    assign o_base_cnt = r_base_cnt;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Directed-plus-random bench for freq_meas_ctrl; expected counts come from the
// closed-form reciprocal-meter rule k = floor(GATE/P)+1 periods, k*P sysclk cycles.
module tb_freq_meas_ctrl;

    localparam int CNT_W   = 32;
    localparam int GATE    = 100;
    localparam int TIMEOUT = 500;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fx = 1'b0;
    logic             start = 1'b0;
    logic             cont_mode = 1'b0;
    logic             abort = 1'b0;
    logic             ack = 1'b0;
    logic [2:0]       rd_sel = 3'd0;
    logic [7:0]       data_out;
    logic             busy, valid, irq, timeout, ovf;
    logic [CNT_W-1:0] fx_cnt, base_cnt;

    int vecs = 0;
    int errs = 0;

    // fx generator: 0 = held low, 1 = periodic with period P sysclk cycles, 2 = held high
    int fx_mode = 0;
    int P = 10;
    int ph = 0;

    freq_meas_ctrl #(
        .CNT_W(CNT_W), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .i_sysclk(clk), .i_reset(rst_n), .i_fx(fx), .i_start(start),
        .i_cont_mode(cont_mode), .i_abort(abort), .i_ack(ack), .i_rd_sel(rd_sel),
        .o_data_out(data_out), .o_busy(busy), .o_valid(valid), .o_irq(irq),
        .o_timeout(timeout), .o_ovf(ovf), .o_fx_cnt(fx_cnt), .o_base_cnt(base_cnt)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        ph = ph + 1;
        if (ph >= P) ph = 0;
        case (fx_mode)
            1:       fx = (ph < P / 2);
            2:       fx = 1'b1;
            default: fx = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1; tick(1); ack = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1; tick(1); abort = 1'b0;
    endtask

    task automatic wait_irq(input string tag, output bit all_busy);
        bit seen = 1'b0;
        all_busy = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (irq) begin
                seen = 1'b1;
                break;
            end
            if (!busy) all_busy = 1'b0;
            tick(1);
        end
        chk({tag, "_irq_seen"}, 64'(seen), 64'd1);
    endtask

    // Reference: the gate closes on the first fx edge strictly after GATE cycles.
    task automatic model(input int per, output logic [31:0] efx, output logic [31:0] ebase);
        int k;
        k = GATE / per + 1;
        efx = 32'(k);
        ebase = 32'(k * per);
    endtask

    task automatic set_fx_period(input int per);
        P = per;
        fx_mode = 1;
        tick(2 * per + 4);
    endtask

    task automatic check_result(input string tag, input logic [31:0] efx, input logic [31:0] ebase);
        chk({tag, "_fx_cnt"}, 64'(fx_cnt), 64'(efx));
        chk({tag, "_base_cnt"}, 64'(base_cnt), 64'(ebase));
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic readout(input string tag, input logic [31:0] efx, input logic [31:0] ebase);
        logic [63:0] pair;
        pair = {ebase, efx};
        rd_sel = 3'd0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk($sformatf("%s_byte%0d", tag, i), 64'(data_out), (pair >> (8 * i)) & 64'hFF);
            if (i < 7) rd_sel = 3'(i + 1);
        end
    endtask

    task automatic measure(input string tag, input int per, input bit do_read);
        logic [31:0] efx, ebase;
        bit bz;
        set_fx_period(per);
        pulse_start();
        chk({tag, "_busy_arm"}, 64'(busy), 64'd1);
        wait_irq(tag, bz);
        chk({tag, "_busy_until_irq"}, 64'(bz), 64'd1);
        model(per, efx, ebase);
        check_result(tag, efx, ebase);
        if (do_read) readout(tag, efx, ebase);
        pulse_ack();
        chk({tag, "_valid_after_ack"}, 64'(valid), 64'd0);
        chk({tag, "_irq_after_ack"}, 64'(irq), 64'd0);
    endtask

    initial begin
        logic [31:0] efx, ebase;
        bit bz;

        // Reset state
        tick(3);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_fx_cnt", 64'(fx_cnt), 64'd0);
        chk("rst_base_cnt", 64'(base_cnt), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // Directed periods from the plan, then random ones
        measure("p10", 10, 1'b0);
        measure("p7", 7, 1'b1);
        for (int r = 0; r < 4; r++)
            measure($sformatf("rnd%0d", r), int'($urandom_range(4, 40)), 1'b1);

        // ARM timeout with fx held low: irq exactly TIMEOUT cycles after ARM entry
        fx_mode = 0;
        tick(5);
        pulse_start();
        tick(TIMEOUT - 1);
        chk("to_irq_early", 64'(irq), 64'd0);
        tick(1);
        chk("to_irq_on_time", 64'(irq), 64'd1);
        chk("to_timeout", 64'(timeout), 64'd1);
        chk("to_fx_cnt", 64'(fx_cnt), 64'd0);
        chk("to_base_cnt", 64'(base_cnt), 64'd0);
        chk("to_ovf", 64'(ovf), 64'd0);
        pulse_ack();
        chk("to_valid_ack", 64'(valid), 64'd0);

        // start is ignored while a result is pending in DONE
        measure("pre_ignore", 10, 1'b0);

        // Continuous mode: three back-to-back results, busy between ack and irq
        cont_mode = 1'b1;
        set_fx_period(10);
        model(10, efx, ebase);
        pulse_start();
        for (int n = 0; n < 3; n++) begin
            wait_irq($sformatf("cont%0d", n), bz);
            chk($sformatf("cont%0d_busy_gap", n), 64'(bz), 64'd1);
            chk($sformatf("cont%0d_fx_cnt", n), 64'(fx_cnt), 64'(efx));
            chk($sformatf("cont%0d_base_cnt", n), 64'(base_cnt), 64'(ebase));
            if (n == 0) begin
                start = 1'b1; tick(1); start = 1'b0;
                chk("cont_start_in_done_valid", 64'(valid), 64'd1);
                tick(4);
            end else begin
                tick(5);
            end
            if (n == 2) cont_mode = 1'b0;
            pulse_ack();
            chk($sformatf("cont%0d_busy_after_ack", n), 64'(busy), 64'(n != 2));
            chk($sformatf("cont%0d_valid_after_ack", n), 64'(valid), 64'd0);
        end

        // Abort in mid-COUNT keeps the previous results
        pulse_start();
        tick(60);
        pulse_abort();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_fx_kept", 64'(fx_cnt), 64'(efx));
        chk("abort_base_kept", 64'(base_cnt), 64'(ebase));

        // start and abort together: stays idle
        start = 1'b1; abort = 1'b1; tick(1); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'd0);
        tick(3);
        chk("start_abort_busy_later", 64'(busy), 64'd0);

        // Abort in DONE clears valid/irq but not the results
        pulse_start();
        wait_irq("abort_done", bz);
        pulse_abort();
        chk("abort_done_valid", 64'(valid), 64'd0);
        chk("abort_done_irq", 64'(irq), 64'd0);
        chk("abort_done_fx", 64'(fx_cnt), 64'(efx));
        chk("abort_done_base", 64'(base_cnt), 64'(ebase));

        // Reset asserted while in CLOSE: fx held high after one opening edge
        fx_mode = 0;
        tick(5);
        pulse_start();
        tick(4);
        fx_mode = 2;
        tick(GATE + 10);
        chk("close_busy_before_rst", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick(1);
        chk("close_rst_data_out", 64'(data_out), 64'd0);
        chk("close_rst_busy", 64'(busy), 64'd0);
        chk("close_rst_valid", 64'(valid), 64'd0);
        chk("close_rst_timeout", 64'(timeout), 64'd0);
        chk("close_rst_ovf", 64'(ovf), 64'd0);
        chk("close_rst_fx_cnt", 64'(fx_cnt), 64'd0);
        chk("close_rst_base_cnt", 64'(base_cnt), 64'd0);
        rst_n = 1'b1;
        fx_mode = 0;
        tick(3);
        measure("post_rst", 10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
